ex_mem_buffer: RTL and testbench

EX_MEM_BUFFER -- requirements
Module: ex_mem_buffer

---
 rtl/ex_mem_buffer.sv | 184 ++++++++++++++++++
 tb/tb_ex_mem_buffer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_buffer.sv
// ---------------------------------------------------------------------------
// ex_mem_buffer
//
// Two-entry elastic pipeline buffer between the execute and memory stages.
// Packets from the execute stage are accepted with a valid/ready handshake,
// held in FIFO order and presented to the memory stage, which drains them
// with its own valid/ready handshake. The head packet also drives the
// register-forwarding outputs. A saturating counter records how many cycles
// the execute stage was held off by a full buffer.
//
// Ports
//   clk_i          : clock, all state updates on the rising edge
//   rst_i          : asynchronous active-low reset
//   flush_i        : synchronous flush of all buffered packets
//   valid_i        : execute stage presents a packet
//   ready_o        : buffer can accept a packet this cycle
//   ALUResult_i    : execute-stage result            (DATA_W)
//   Zero_i         : execute-stage equality flag
//   RS2data_i      : store data                      (DATA_W)
//   RDaddr_i       : destination register            (5)
//   Ctrl_i         : {RegWrite, MemtoReg, MemRead, MemWrite}
//   valid_o        : head packet is valid
//   ready_i        : memory stage accepts the head packet
//   ALUResult_o .. Ctrl_o : head packet fields, zero while empty
//   Fwd_RegWrite_o : head packet will write a nonzero register
//   Fwd_RDaddr_o   : forwarding destination (equals RDaddr_o)
//   stall_cnt_o    : saturating count of backpressure cycles
// ---------------------------------------------------------------------------
module ex_mem_buffer #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] ALUResult_i,
  input  logic              Zero_i,
  input  logic [DATA_W-1:0] RS2data_i,
  input  logic [4:0]        RDaddr_i,
  input  logic [3:0]        Ctrl_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] ALUResult_o,
  output logic              Zero_o,
  output logic [DATA_W-1:0] RS2data_o,
  output logic [4:0]        RDaddr_o,
  output logic [3:0]        Ctrl_o,
  output logic              Fwd_RegWrite_o,
  output logic [4:0]        Fwd_RDaddr_o,
  output logic [7:0]        stall_cnt_o
);

  // One buffered packet; field order matches the port list.
  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic              zero;
    logic [DATA_W-1:0] rs2_data;
    logic [4:0]        rd_addr;
    logic [3:0]        ctrl;
  } packet_t;

  localparam logic [1:0] DEPTH = 2'd2;

  // Control state
  logic [1:0] count;
  logic       rd_ptr;
  logic       wr_ptr;
  logic [7:0] stall_cnt;

  // Storage and datapath
  packet_t    slots [2];
  packet_t    in_pkt;
  packet_t    head_pkt;
  packet_t    out_pkt;

  logic       push;
  logic       pop;

  // -------------------------------------------------------------------------
  // Handshake decode. ready_o depends on registered occupancy only, so there
  // is no combinational path from ready_i back to the execute stage; a slot
  // freed by a pop at count 2 is offered again only on the following cycle.
  // -------------------------------------------------------------------------
  assign ready_o = (count < DEPTH);
  assign valid_o = (count != 2'd0);
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  assign in_pkt = '{
    alu_result: ALUResult_i,
    zero:       Zero_i,
    rs2_data:   RS2data_i,
    rd_addr:    RDaddr_i,
    ctrl:       Ctrl_i
  };

  // -------------------------------------------------------------------------
  // Occupancy and pointers. Flush wins over any same-cycle push or pop.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (flush_i) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Packet storage.
  // NOTE: the slots are deliberately left out of reset; nothing observes a
  // slot unless occupancy says it holds a packet, and the outputs are forced
  // to zero while empty, so stale contents are never visible.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      slots[wr_ptr] <= in_pkt;
    end
  end

  // -------------------------------------------------------------------------
  // Output selection: head slot while occupied, all zeros while empty.
  // NOTE: out_pkt is given a default before the conditional so every path
  // assigns it and no latch is inferred.
  // -------------------------------------------------------------------------
  assign head_pkt = slots[rd_ptr];

  always_comb begin
    out_pkt = '0;
    if (valid_o) begin
      out_pkt = head_pkt;
    end
  end

  assign ALUResult_o = out_pkt.alu_result;
  assign Zero_o      = out_pkt.zero;
  assign RS2data_o   = out_pkt.rs2_data;
  assign RDaddr_o    = out_pkt.rd_addr;
  assign Ctrl_o      = out_pkt.ctrl;

  // Forwarding: writes to x0 are architecturally discarded, so they are not
  // advertised as register writes.
  assign Fwd_RDaddr_o   = out_pkt.rd_addr;
  assign Fwd_RegWrite_o = valid_o & out_pkt.ctrl[3] & (out_pkt.rd_addr != 5'd0);

  // -------------------------------------------------------------------------
  // Backpressure statistics. Counts every cycle the execute stage offers a
  // packet the buffer cannot take. It survives flushes so that a pipeline
  // redirect does not erase the performance history; only reset clears it.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= 8'd0;
    end else if (valid_i && !ready_o && (stall_cnt != 8'hFF)) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;

  // -------------------------------------------------------------------------
  // Structural invariants
  // -------------------------------------------------------------------------
  a_count_range : assert property (@(posedge clk_i) disable iff (!rst_i)
    count <= DEPTH);

  a_ptr_consistent : assert property (@(posedge clk_i) disable iff (!rst_i)
    (count == DEPTH) || (count == 2'd0) ? (rd_ptr == wr_ptr) : (rd_ptr != wr_ptr));

endmodule

// File: tb/tb_ex_mem_buffer.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_buffer
//
// Self-checking bench for ex_mem_buffer. The reference model is a packet
// queue plus a backpressure counter, advanced once per clock from the
// handshake rules: accept when fewer than two packets are held, release the
// oldest when the memory stage is ready, flush empties the queue.
// ---------------------------------------------------------------------------
module tb_ex_mem_buffer;

  typedef struct packed {
    logic [31:0] alu;
    logic        zero;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
  } pkt_t;

  logic        clk_i;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] ALUResult_i;
  logic        Zero_i;
  logic [31:0] RS2data_i;
  logic [4:0]  RDaddr_i;
  logic [3:0]  Ctrl_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] ALUResult_o;
  logic        Zero_o;
  logic [31:0] RS2data_o;
  logic [4:0]  RDaddr_o;
  logic [3:0]  Ctrl_o;
  logic        Fwd_RegWrite_o;
  logic [4:0]  Fwd_RDaddr_o;
  logic [7:0]  stall_cnt_o;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  pkt_t        mq[$];
  int unsigned m_stall = 0;

  ex_mem_buffer #(.DATA_W(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .ALUResult_i    (ALUResult_i),
    .Zero_i         (Zero_i),
    .RS2data_i      (RS2data_i),
    .RDaddr_i       (RDaddr_i),
    .Ctrl_i         (Ctrl_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .ALUResult_o    (ALUResult_o),
    .Zero_o         (Zero_o),
    .RS2data_o      (RS2data_o),
    .RDaddr_o       (RDaddr_o),
    .Ctrl_o         (Ctrl_o),
    .Fwd_RegWrite_o (Fwd_RegWrite_o),
    .Fwd_RDaddr_o   (Fwd_RDaddr_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Everything the DUT shows, packed for a single comparison.
  function automatic logic [89:0] dut_vec();
    return {valid_o, ready_o, ALUResult_o, Zero_o, RS2data_o, RDaddr_o,
            Ctrl_o, Fwd_RegWrite_o, Fwd_RDaddr_o, stall_cnt_o};
  endfunction

  // What the model says the DUT should show right now.
  function automatic logic [89:0] exp_vec();
    pkt_t h;
    logic v;
    logic r;
    logic f;
    h = '0;
    v = (mq.size() != 0);
    r = (mq.size() < 2);
    if (v) h = mq[0];
    f = v & h.ctrl[3] & (h.rd != 5'd0);
    return {v, r, h.alu, h.zero, h.rs2, h.rd, h.ctrl, f, h.rd, m_stall[7:0]};
  endfunction

  // Apply inputs; the non-named fields get random values.
  task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                       input logic [3:0] ctrl, input logic rdy, input logic fl);
    valid_i     = v;
    ALUResult_i = alu;
    Zero_i      = 1'($urandom_range(0, 1));
    RS2data_i   = $urandom;
    RDaddr_i    = rd;
    Ctrl_i      = ctrl;
    ready_i     = rdy;
    flush_i     = fl;
  endtask

  // Advance one clock edge and step the model with the inputs seen at it;
  // returns 1 ns after the edge.
  task automatic tick();
    logic m_ready;
    logic m_valid;
    pkt_t in_p;
    m_ready = (mq.size() < 2);
    m_valid = (mq.size() != 0);
    @(posedge clk_i);
    in_p = '{alu: ALUResult_i, zero: Zero_i, rs2: RS2data_i, rd: RDaddr_i, ctrl: Ctrl_i};
    if (valid_i && !m_ready && m_stall < 255) m_stall++;
    if (flush_i) begin
      mq.delete();
    end else begin
      if (m_valid && ready_i) void'(mq.pop_front());
      if (valid_i && m_ready) mq.push_back(in_p);
    end
    #1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_i = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 4'h0, 1'b0, 1'b0);
    #23;
    compared++;
    if (dut_vec() !== exp_vec() || ready_o !== 1'b1 || valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: got %h expected %h", dut_vec(), exp_vec());
    end
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_single();
    drive(1'b1, 32'h0000_0010, 5'd5, 4'b1000, 1'b1, 1'b0);
    tick();
    compared++;
    if ({valid_o, ALUResult_o, Fwd_RegWrite_o, Fwd_RDaddr_o} !== {1'b1, 32'h10, 1'b1, 5'd5}
        || dut_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL single_head: got %h expected %h", dut_vec(), exp_vec());
    end
    drive(1'b0, 32'h0, 5'd0, 4'h0, 1'b1, 1'b0);
    tick();
    compared++;
    if (valid_o !== 1'b0 || dut_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL single_drained: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_fill_backpressure();
    drive(1'b1, 32'h1, 5'd1, 4'b1000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h2, 5'd2, 4'b1000, 1'b0, 1'b0);
    tick();
    compared++;
    if (ready_o !== 1'b0 || dut_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL fill_ready_low: got %h expected %h", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h99, 5'd9, 4'b1000, 1'b0, 1'b0);
      tick();
    end
    compared++;
    if (stall_cnt_o !== 8'd3 || ALUResult_o !== 32'h1 || dut_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL fill_stall_cnt: got %h expected %h", dut_vec(), exp_vec());
    end
    drive(1'b0, 32'h0, 5'd0, 4'h0, 1'b1, 1'b0);
    tick();
    compared++;
    if (ALUResult_o !== 32'h2 || valid_o !== 1'b1 || dut_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL fill_order_b: got %h expected %h", dut_vec(), exp_vec());
    end
    tick();
    compared++;
    if (valid_o !== 1'b0 || dut_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL fill_drained: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_push_pop_count1();
    drive(1'b1, 32'h1, 5'd3, 4'b1100, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h3, 5'd4, 4'b1010, 1'b1, 1'b0);
    tick();
    compared++;
    if ({valid_o, ready_o, ALUResult_o} !== {1'b1, 1'b1, 32'h3} || dut_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL push_pop_count1: got %h expected %h", dut_vec(), exp_vec());
    end
    drive(1'b0, 32'h0, 5'd0, 4'h0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_x0_write();
    drive(1'b1, 32'hABCD, 5'd0, 4'b1000, 1'b0, 1'b0);
    tick();
    compared++;
    if ({valid_o, Fwd_RegWrite_o} !== 2'b10 || dut_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL x0_write: got %h expected %h", dut_vec(), exp_vec());
    end
    drive(1'b0, 32'h0, 5'd0, 4'h0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 5'($urandom), 4'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      tick();
      compared++;
      if (dut_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL random_cycle_%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, $urandom, 5'($urandom), 4'($urandom), 1'b0, 1'b0);
      tick();
    end
    compared++;
    if (stall_cnt_o !== 8'd255 || ready_o !== 1'b0 || dut_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL stall_saturate: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  // Runs with the buffer full and the counter saturated, so the flush cycle
  // (valid_i high, buffer full) leaves the counter where it was.
  task automatic test_flush();
    drive(1'b1, 32'h77, 5'd7, 4'b1000, 1'b1, 1'b1);
    tick();
    compared++;
    if ({valid_o, ready_o, ALUResult_o, Zero_o, RS2data_o, RDaddr_o, Ctrl_o, stall_cnt_o}
        !== {1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 5'd0, 4'h0, 8'd255}
        || dut_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL flush_clears: got %h expected %h", dut_vec(), exp_vec());
    end
    drive(1'b1, 32'h55, 5'd6, 4'b1001, 1'b0, 1'b0);
    tick();
    compared++;
    if (dut_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL flush_then_push: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_async_reset();
    // Top up to two packets.
    drive(1'b1, 32'h88, 5'd8, 4'b1000, 1'b0, 1'b0);
    tick();
    compared++;
    if (ready_o !== 1'b0 || valid_o !== 1'b1 || dut_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL async_pre_full: got %h expected %h", dut_vec(), exp_vec());
    end
    drive(1'b0, 32'h0, 5'd0, 4'h0, 1'b0, 1'b0);
    #1;
    rst_i = 1'b0;
    mq.delete();
    m_stall = 0;
    #1;
    compared++;
    if ({valid_o, ready_o, ALUResult_o, RDaddr_o, Fwd_RegWrite_o, stall_cnt_o}
        !== {1'b0, 1'b1, 32'h0, 5'd0, 1'b0, 8'd0} || dut_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL async_reset: got %h expected %h", dut_vec(), exp_vec());
    end
    #1;
    rst_i = 1'b1;
    tick();
    drive(1'b1, 32'h1234, 5'd12, 4'b1000, 1'b0, 1'b0);
    #1;
    compared++;
    if (valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL post_reset_no_bypass: got valid_o=%b expected 0", valid_o);
    end
    tick();
    compared++;
    if ({valid_o, ALUResult_o} !== {1'b1, 32'h1234} || dut_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL post_reset_push: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_backpressure();
    test_push_pop_count1();
    test_x0_write();
    test_random();
    test_saturate();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
